spi_fifo_ctrl: RTL

- Parametrised successor to the SPI block's single-clock data FIFO.
- Width and depth are set by parameters; depth need not be a power of two.
- Adds fill level, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags.
- Sits between the SPI shift engine and the bus-side register interface, one instance per direction (TX and RX).

---
 rtl/spi_fifo_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/spi_fifo_ctrl.sv
// Parametrised single-clock SPI data FIFO with fill level, almost-full/empty and sticky error flags.
// Define SPI_FIFO_FWFT_EN for first-word-fall-through reads; the default is a registered one-cycle read.
module spi_fifo_ctrl #(
  parameter  int DATA_WIDTH    = 8,
  parameter  int FIFO_DEPTH    = 16,
  parameter  int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter  int AEMPTY_THRESH = 2,
  localparam int LVL_W         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  wr_i,
  input  logic                  rd_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  rvalid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [LVL_W-1:0]      level_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AFULL_THRESH);
  localparam logic [LVL_W-1:0] LVL_AE   = LVL_W'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  rd_acc;
  logic                  wr_acc;

  assign empty_o        = (level == '0);
  assign full_o         = (level == LVL_FULL);
  assign almost_full_o  = (level >= LVL_AF);
  assign almost_empty_o = (level <= LVL_AE);
  assign level_o        = level;

  // A flush cycle swallows both requests, so acceptance is gated by clr_i here.
  assign rd_acc = rd_i && !empty_o && !clr_i;
  assign wr_acc = wr_i && (!full_o || rd_acc) && !clr_i;

  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (clr_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (wr_i && !wr_acc) begin
        overflow_o <= 1'b1;
      end
      if (rd_i && empty_o) begin
        underflow_o <= 1'b1;
      end
    end
  end

`ifdef SPI_FIFO_FWFT_EN
  assign data_o   = mem[rd_ptr];
  assign rvalid_o = !empty_o;
`else
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o   <= '0;
      rvalid_o <= 1'b0;
    end else if (clr_i) begin
      rvalid_o <= 1'b0;
    end else begin
      rvalid_o <= rd_acc;
      if (rd_acc) begin
        data_o <= mem[rd_ptr];
      end
    end
  end
`endif

endmodule
